// File: rtl/pic_boot_loader.sv
// Boot loader for a PIC core: copies PROG_WORDS 14-bit words from boot ROM into
// program RAM, holds the core in reset for HOLD_CYCLES more cycles, then releases it.
module pic_boot_loader #(
  parameter int PROG_WORDS  = 1024,
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  output logic              rom_re,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [13:0]       rom_data,
  output logic              pram_we,
  output logic [ADDR_W-1:0] pram_addr,
  output logic [13:0]       pram_data,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_WORDS - 1);
  localparam logic [ADDR_W:0]   WC_MAX    = (ADDR_W + 1)'(PROG_WORDS);
  localparam logic [7:0]        HOLD_INIT = 8'(HOLD_CYCLES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                pram_we_q, pram_we_d;
  logic [ADDR_W-1:0]   pram_addr_q, pram_addr_d;
  logic [7:0]          hold_q, hold_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic                core_reset_q, core_reset_d;

  // State register: every register clears asynchronously, core_reset sets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      pram_we_q    <= 1'b0;
      pram_addr_q  <= '0;
      hold_q       <= '0;
      wc_q         <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      pram_we_q    <= pram_we_d;
      pram_addr_q  <= pram_addr_d;
      hold_q       <= hold_d;
      wc_q         <= wc_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Next-state logic; reload is only honoured in RUN and never queued.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    hold_d       = hold_q;
    wc_d         = wc_q;
    pram_we_d    = rom_re;
    pram_addr_d  = rom_addr;
    case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD: begin
        if (rd_ptr_q == LAST_ADDR) state_d = S_DRAIN;
        else                       rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      S_DRAIN: begin
        state_d = S_HOLD;
        hold_d  = HOLD_INIT;
      end
      S_HOLD: begin
        hold_d = hold_q - 8'd1;
        if (hold_q <= 8'd1) state_d = S_RUN;
      end
      S_RUN: begin
        if (reload) begin
          state_d  = S_LOAD;
          rd_ptr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_RUN && reload)      wc_d = '0;
    else if (pram_we_q && wc_q != WC_MAX) wc_d = wc_q + (ADDR_W + 1)'(1);
    // core_reset is registered so it drops cleanly on the edge entering RUN.
    core_reset_d = (state_d != S_RUN);
  end

  always_comb begin
    rom_re     = (state_q == S_LOAD);
    rom_addr   = rd_ptr_q;
    pram_we    = pram_we_q;
    pram_addr  = pram_addr_q;
    pram_data  = pram_we_q ? rom_data : 14'h0;
    core_reset = core_reset_q;
    busy       = (state_q == S_LOAD) || (state_q == S_DRAIN) || (state_q == S_HOLD);
    done       = (state_q == S_RUN);
    word_count = wc_q;
    state_o    = state_q;
  end

endmodule

// File: tb/tb_pic_boot_loader.sv
// Directed bench for pic_boot_loader with PROG_WORDS=8, HOLD_CYCLES=4 and a
// registered ROM model returning 14'h3000 | addr.
module tb_pic_boot_loader;

  localparam int PW = 8;
  localparam int AW = 4;
  localparam int HC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reload = 1'b0;
  logic          rom_re;
  logic [AW-1:0] rom_addr;
  logic [13:0]   rom_data = 14'h0;
  logic          pram_we;
  logic [AW-1:0] pram_addr;
  logic [13:0]   pram_data;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [AW+13:0] exp_q[$];

  pic_boot_loader #(.PROG_WORDS(PW), .ADDR_W(AW), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .reload(reload),
    .rom_re(rom_re), .rom_addr(rom_addr), .rom_data(rom_data),
    .pram_we(pram_we), .pram_addr(pram_addr), .pram_data(pram_data),
    .core_reset(core_reset), .busy(busy), .done(done),
    .word_count(word_count), .state_o(state_dbg)
  );

  always #5 clk = ~clk;

  // Boot ROM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rom_re) rom_data <= 14'h3000 | {10'h0, rom_addr};
    else        rom_data <= 14'h3fff;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every ROM read must come back as the next RAM write.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (pram_we) begin
        check_eq("we_phase", {31'h0, busy && !done}, 32'h1);
        check_eq("pram_addr_max", {31'h0, pram_addr <= AW'(PW - 1)}, 32'h1);
        if (exp_q.size() == 0) check_eq("sb_underflow", 32'h1, 32'h0);
        else check_eq("sb_write", {14'h0, pram_addr, pram_data}, {14'h0, exp_q.pop_front()});
      end
      if (rom_re) begin
        check_eq("rom_addr_max", {31'h0, rom_addr <= AW'(PW - 1)}, 32'h1);
        exp_q.push_back({rom_addr, 14'h3000 | {10'h0, rom_addr}});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, {29'h0, state_dbg}, 32'h0);
    check_eq({tag, "_core_reset"}, {31'h0, core_reset}, 32'h1);
    check_eq({tag, "_rom_re"}, {31'h0, rom_re}, 32'h0);
    check_eq({tag, "_pram_we"}, {31'h0, pram_we}, 32'h0);
    check_eq({tag, "_rom_addr"}, {28'h0, rom_addr}, 32'h0);
    check_eq({tag, "_pram_addr"}, {28'h0, pram_addr}, 32'h0);
    check_eq({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check_eq({tag, "_done"}, {31'h0, done}, 32'h0);
    check_eq({tag, "_word_count"}, {27'h0, word_count}, 32'h0);
  endtask

  // Entered at the negedge right after LOAD entry (cycle 0). Walks the whole
  // pass; optional reload pulses and a reset abort at given cycles (-1 = none).
  task automatic run_pass(input int reload_c1, input int reload_c2, input int abort_c);
    for (int c = 0; c <= PW + 1 + HC; c++) begin
      reload = 1'b0;
      if (c == abort_c) begin
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        return;
      end
      if (c < PW) begin
        check_eq("load_rom_re", {31'h0, rom_re}, 32'h1);
        check_eq("load_rom_addr", {28'h0, rom_addr}, 32'(c));
      end else begin
        check_eq("rom_re_low", {31'h0, rom_re}, 32'h0);
      end
      if (c >= 1 && c <= PW) begin
        check_eq("pram_we", {31'h0, pram_we}, 32'h1);
        check_eq("pram_addr", {28'h0, pram_addr}, 32'(c - 1));
        check_eq("pram_data", {18'h0, pram_data}, 32'h3000 + 32'(c - 1));
      end else begin
        check_eq("pram_we_low", {31'h0, pram_we}, 32'h0);
      end
      check_eq("word_count", {27'h0, word_count}, (c == 0) ? 32'h0 : ((c - 1 > PW) ? 32'(PW) : 32'(c - 1)));
      if (c < PW + 1 + HC) begin
        check_eq("busy", {31'h0, busy}, 32'h1);
        check_eq("done", {31'h0, done}, 32'h0);
        check_eq("core_reset", {31'h0, core_reset}, 32'h1);
      end else begin
        check_eq("run_core_reset", {31'h0, core_reset}, 32'h0);
        check_eq("run_done", {31'h0, done}, 32'h1);
        check_eq("run_busy", {31'h0, busy}, 32'h0);
        check_eq("run_word_count", {27'h0, word_count}, 32'(PW));
        check_eq("sb_empty", 32'(exp_q.size()), 32'h0);
        return;
      end
      if (c == reload_c1 || c == reload_c2) reload = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    run_pass(-1, -1, -1);

    // RUN holds its outputs while idle.
    repeat (3) @(negedge clk);
    check_eq("run_hold_done", {31'h0, done}, 32'h1);
    check_eq("run_hold_core_reset", {31'h0, core_reset}, 32'h0);
    check_eq("run_hold_pram_we", {31'h0, pram_we}, 32'h0);

    pulse_reload();
    run_pass(-1, -1, -1);

    // Reload pulses in LOAD and HOLD must not disturb the pass.
    pulse_reload();
    run_pass(3, PW + 2, -1);
    repeat (2) @(negedge clk);
    check_eq("ignored_reload_done", {31'h0, done}, 32'h1);

    // Reset during the fifth write, then a clean restart from address 0.
    pulse_reload();
    run_pass(-1, -1, 5);
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_hold");
    reset = 1'b0;
    @(negedge clk);
    run_pass(-1, -1, -1);

    // Reset in RUN brings core_reset back immediately.
    reset = 1'b1;
    #1;
    check_eq("run_reset_core_reset", {31'h0, core_reset}, 32'h1);
    check_eq("run_reset_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    check_eq("run_reset_core_reset_held", {31'h0, core_reset}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    run_pass(-1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
